// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shifter with a load/ready handshake. Back-to-back words
// are accepted during the last-bit cycle, so consecutive words leave no idle gap.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;

    // The bit on the wire is always at the leading end of the shift register.
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        out_d      = out_q;
        valid_d    = valid_q;
        last_d     = last_q;
        load_ready = 1'b0;

        case (state_q)
            StIdle: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    sr_d    = load_data;
                    out_d   = lead_bit(load_data);
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end
            end
            StShift: begin
                load_ready = last_q & ser_en;
                if (ser_en) begin
                    if (cnt_q == LastCnt) begin
                        if (load_valid) begin
                            cnt_d   = '0;
                            sr_d    = load_data;
                            out_d   = lead_bit(load_data);
                            valid_d = 1'b1;
                            last_d  = 1'b0;
                        end else begin
                            state_d = StIdle;
                            cnt_d   = '0;
                            sr_d    = '0;
                            out_d   = 1'b0;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                        end
                    end else begin
                        cnt_d  = cnt_q + CntW'(1);
                        sr_d   = (LSB_FIRST != 0) ? (sr_q >> 1) : (sr_q << 1);
                        out_d  = lead_bit(sr_d);
                        last_d = (cnt_d == LastCnt);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                sr_d    = '0;
                out_d   = 1'b0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sr_q    <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign ser_out   = out_q;
    assign ser_valid = valid_q;
    assign ser_last  = last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share stimulus and are
// checked against a word/bit-index model, a constant vector table and directed sequences.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         load_valid = 1'b0;
    logic         ser_en = 1'b0;
    logic         rdy_m, out_m, val_m, last_m;
    logic         rdy_l, out_l, val_l, last_l;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(0)) dut_m (
        .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
        .load_ready(rdy_m), .ser_en(ser_en), .ser_out(out_m), .ser_valid(val_m),
        .ser_last(last_m)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1)) dut_l (
        .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
        .load_ready(rdy_l), .ser_en(ser_en), .ser_out(out_l), .ser_valid(val_l),
        .ser_last(last_l)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: the word in flight and the index of the bit currently on the wire.
    bit           m_active;
    logic [W-1:0] m_word;
    int           m_idx;

    // Values seen on the most recent drive() sample, for the directed sequences.
    logic s_out_m, s_val_m, s_out_l;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_word   = '0;
        m_idx    = 0;
    endtask

    function automatic logic exp_bit(input bit lsb);
        if (!m_active) return 1'b0;
        return lsb ? m_word[m_idx] : m_word[W-1-m_idx];
    endfunction

    function automatic logic exp_ready();
        return !m_active || (m_idx == W - 1 && ser_en);
    endfunction

    // Call at a negedge: apply inputs, check both DUTs, cross one posedge, advance the model.
    task automatic drive(input logic lv, input logic [W-1:0] d, input logic en);
        bit rdy;
        load_valid = lv;
        load_data  = d;
        ser_en     = en;
        #1;
        rdy = exp_ready();
        chk("ready_m", rdy_m, rdy);
        chk("ready_l", rdy_l, rdy);
        chk("out_m", out_m, exp_bit(0));
        chk("out_l", out_l, exp_bit(1));
        chk("valid_m", val_m, m_active);
        chk("valid_l", val_l, m_active);
        chk("last_m", last_m, m_active && m_idx == W - 1);
        chk("last_l", last_l, m_active && m_idx == W - 1);
        s_out_m = out_m;
        s_val_m = val_m;
        s_out_l = out_l;
        @(posedge clk);
        if (rdy && lv) begin
            m_active = 1;
            m_word   = d;
            m_idx    = 0;
        end else if (m_active && en) begin
            if (m_idx == W - 1) m_active = 0;
            else m_idx++;
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic         lv;
        logic [W-1:0] d;
        logic         en;
        logic         e_out;
        logic         e_val;
        logic         e_last;
        logic         e_rdy;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic [15:0] acc16;
        logic [7:0]  acc8;
        int          nv;
        int          guard;
        logic [7:0]  a5;

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out", out_m, 1'b0);
        chk("rst_valid", val_m, 1'b0);
        chk("rst_last", last_m, 1'b0);
        chk("rst_ready", rdy_m, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // 0xA5, MSB first, ser_en held high: one bit per cycle, then back to idle.
        a5 = 8'hA5;
        vt[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 1; i <= 8; i++)
            vt[i] = '{1'b0, 8'h00, 1'b1, a5[8-i], 1'b1, (i == 8), (i == 8)};
        vt[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            load_valid = vt[i].lv;
            load_data  = vt[i].d;
            ser_en     = vt[i].en;
            #1;
            chk("tbl_out", out_m, vt[i].e_out);
            chk("tbl_valid", val_m, vt[i].e_val);
            chk("tbl_last", last_m, vt[i].e_last);
            chk("tbl_ready", rdy_m, vt[i].e_rdy);
            drive(vt[i].lv, vt[i].d, vt[i].en);
        end

        // Back-to-back: 0x3C held valid is taken in 0xA5's last-bit cycle.
        drive(1'b1, 8'hA5, 1'b1);
        acc16 = '0;
        nv = 0;
        for (int i = 0; i < 16; i++) begin
            drive(i < 8, 8'h3C, 1'b1);
            acc16 = {acc16[14:0], s_out_m};
            if (s_val_m) nv++;
        end
        chk("b2b_bits", acc16, 16'hA53C);
        chk("b2b_valid_cnt", nv, 16);
        drive(1'b0, 8'h00, 1'b1);

        // Stalled strobe 1,0,0,...: bits hold and order is unchanged.
        drive(1'b1, 8'hF0, 1'b1);
        acc8 = '0;
        nv = 0;
        guard = 0;
        while (m_active && guard < 60) begin
            drive(1'b0, 8'h00, (guard % 3) == 0);
            if (s_val_m && (guard % 3) == 0) begin
                acc8 = {acc8[6:0], s_out_m};
                nv++;
            end
            guard++;
        end
        chk("stall_timeout", guard < 60, 1'b1);
        chk("stall_bits", acc8, 8'hF0);
        chk("stall_cnt", nv, 8);

        // LSB-first instance with 0x01: wire sequence 1,0,0,0,0,0,0,0.
        drive(1'b1, 8'h01, 1'b1);
        acc8 = '0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            acc8 = {acc8[6:0], s_out_l};
        end
        chk("lsb_bits", acc8, 8'h80);
        drive(1'b0, 8'h00, 1'b0);

        // Asynchronous reset between edges while bit 4 of 0xA5 is on the wire.
        drive(1'b1, 8'hA5, 1'b1);
        repeat (4) drive(1'b0, 8'h00, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", out_m, 1'b0);
        chk("arst_valid", val_m, 1'b0);
        chk("arst_last", last_m, 1'b0);
        chk("arst_valid_l", val_l, 1'b0);
        #1 rst_n = 1'b1;
        model_reset();
        #1;
        chk("arst_ready", rdy_m, 1'b1);
        @(negedge clk);
        drive(1'b1, 8'h55, 1'b1);
        acc8 = '0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            acc8 = {acc8[6:0], s_out_m};
        end
        chk("post_rst_bits", acc8, 8'h55);
        drive(1'b0, 8'h00, 1'b1);

        // A load offered mid-word is ignored and the word in flight is undisturbed.
        drive(1'b1, 8'hC3, 1'b1);
        acc8 = '0;
        for (int i = 0; i < 8; i++) begin
            drive(i > 1 && i < 5, 8'h3A, 1'b1);
            acc8 = {acc8[6:0], s_out_m};
        end
        chk("midload_bits", acc8, 8'hC3);
        drive(1'b0, 8'h00, 1'b1);

        // Random stimulus against the model.
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
